mult_div_unit: RTL and testbench

- Multi-cycle signed multiply/divide responder; consumes the `multOp`/`divOp` start strobes issued by the ALU control decoder.
- Computes a signed 64-bit product, or a signed quotient and remainder, over WIDTH iterations.
- Results land in HI/LO, which the datapath stores when StoreMD is set.
- Provides `busy` and `done` so the control FSM can stall until the result is valid.

---
 rtl/md_pkg.sv | 18 +
 rtl/md_div_step.sv | 24 ++
 rtl/mult_div_unit.sv | 167 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Build option: MD_SINGLE_CYCLE_MULT_EN (single-cycle multiply).
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH) + 1;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } md_state_t;

endpackage

// File: rtl/md_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Used by mult_div_unit; no build options.
module md_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_sh;
  logic           w_ok;

  assign w_sh = {i_rem, i_quo[WIDTH-1]};
  assign w_ok = (w_sh >= {1'b0, i_div});

  // remainder stays below the divisor, so W bits hold the difference
  assign o_rem = w_ok ? (w_sh[WIDTH-1:0] - i_div)
                      : w_sh[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ok};

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply/divide with HI/LO results.
// Build option: MD_SINGLE_CYCLE_MULT_EN (single-cycle multiply).
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multOp,
  input  logic             divOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_t          r_state;
  md_state_t          w_next;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_m;
  logic [CW-1:0]      r_cnt;
  logic               r_op;
  logic               r_sa;
  logic               r_sb;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_dz;

  logic               w_start;
  logic               w_op;
  logic               w_div0;
  logic               w_fast;
  logic               w_last;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_n;
  logic [WIDTH-1:0]   w_rem_n;
  logic [WIDTH-1:0]   w_quo_n;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quo_fix;

  assign w_start = (r_state == IDLE) && (multOp || divOp);
  assign w_op    = divOp ? OP_DIV : OP_MULT;
  assign w_div0  = w_start && divOp && (B == '0);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  assign w_abs_a = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign w_abs_b = B[WIDTH-1] ? (~B + 1'b1) : B;

`ifdef MD_SINGLE_CYCLE_MULT_EN
  logic [2*WIDTH-1:0] w_prod_fast;
  assign w_prod_fast =
    $signed({{WIDTH{A[WIDTH-1]}}, A}) *
    $signed({{WIDTH{B[WIDTH-1]}}, B});
  assign w_fast = w_start && !divOp;
`else
  assign w_fast = 1'b0;
`endif

  // shift-add: low half holds the unused multiplier bits
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_n   = {w_mul_sum, r_acc[WIDTH-1:1]};

  md_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_rem (r_acc[2*WIDTH-1:WIDTH]),
    .i_quo (r_acc[WIDTH-1:0]),
    .i_div (r_m),
    .o_rem (w_rem_n),
    .o_quo (w_quo_n)
  );

  assign w_prod_fix = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
  assign w_quo_fix  = (r_sa ^ r_sb) ? (~r_acc[WIDTH-1:0] + 1'b1)
                                    : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_sa ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                           : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_div0 || w_fast) w_next = DONE;
        else if (w_start)     w_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = FIX;
      end
      FIX: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_m   <= '0;
      r_cnt <= '0;
      r_op  <= OP_MULT;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_dz  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_dz  <= w_div0;
            r_cnt <= '0;
            r_op  <= w_op;
            r_sa  <= A[WIDTH-1];
            r_sb  <= B[WIDTH-1];
            r_m   <= divOp ? w_abs_b : w_abs_a;
            r_acc <= {{WIDTH{1'b0}},
                      divOp ? w_abs_a : w_abs_b};
`ifdef MD_SINGLE_CYCLE_MULT_EN
            if (!divOp) {r_hi, r_lo} <= w_prod_fast;
`endif
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CW'(1);
          r_acc <= (r_op == OP_DIV) ? {w_rem_n, w_quo_n}
                                    : w_mul_n;
        end
        FIX: begin
          if (r_op == OP_DIV) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign HI      = r_hi;
  assign LO      = r_lo;
  assign divZero = r_dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit.
// Honours MD_SINGLE_CYCLE_MULT_EN for multiply timing.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         multOp;
  logic         divOp;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         busy;
  logic         done;
  logic         divZero;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .multOp  (multOp),
    .divOp   (divOp),
    .A       (A),
    .B       (B),
    .HI      (HI),
    .LO      (LO),
    .busy    (busy),
    .done    (done),
    .divZero (divZero)
  );

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
    int           nbusy;
  } exp_t;

  exp_t         sb[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] m_hi     = '0;
  logic [W-1:0] m_lo     = '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic d,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t   e;
    int     sa;
    int     sbv;
    int     q;
    int     r;
    longint p;
    sa      = a;
    sbv     = b;
    e.hi    = m_hi;
    e.lo    = m_lo;
    e.dz    = 1'b0;
    e.lat   = W + 2;
    e.nbusy = W + 1;
    if (d) begin
      if (b == '0) begin
        e.dz    = 1'b1;
        e.lat   = 1;
        e.nbusy = 0;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.lo = 32'h8000_0000;
        e.hi = '0;
      end else begin
        q    = sa / sbv;
        r    = sa % sbv;
        e.lo = q;
        e.hi = r;
      end
    end else begin
      p    = longint'(sa) * longint'(sbv);
      e.hi = p[63:32];
      e.lo = p[31:0];
`ifdef MD_SINGLE_CYCLE_MULT_EN
      e.lat   = 1;
      e.nbusy = 0;
`endif
    end
    return e;
  endfunction

  task automatic run_op(input logic m, input logic d,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input int inj, input bit dstrobe,
                        input string tag);
    exp_t e;
    exp_t g;
    int   cyc;
    int   nb;
    e = model(d, a, b);
    sb.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    @(negedge clk);
    multOp = m;
    divOp  = d;
    A      = a;
    B      = b;
    @(negedge clk);
    multOp = 1'b0;
    divOp  = 1'b0;
    A      = $urandom;
    B      = $urandom;
    cyc    = 1;
    nb     = 0;
    while (!done && cyc < 200) begin
      if (busy) nb++;
      multOp = (cyc == inj);
      @(negedge clk);
      cyc++;
    end
    multOp = 1'b0;
    check({tag, "/done"}, 64'(done), 64'd1);
    g = sb.pop_front();
    check({tag, "/hi"}, 64'(HI), 64'(g.hi));
    check({tag, "/lo"}, 64'(LO), 64'(g.lo));
    check({tag, "/dz"}, 64'(divZero), 64'(g.dz));
    check({tag, "/lat"}, 64'(cyc), 64'(g.lat));
    check({tag, "/busy"}, 64'(nb), 64'(g.nbusy));
    if (dstrobe) begin
      multOp = 1'b1;
      A      = 32'd3;
      B      = 32'd3;
    end
    @(negedge clk);
    multOp = 1'b0;
    check({tag, "/pulse"}, 64'(done), 64'd0);
    check({tag, "/idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int ndone;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    reset  = 1'b1;
    multOp = 1'b0;
    divOp  = 1'b0;
    A      = '0;
    B      = '0;
    repeat (2) @(negedge clk);
    check("rst/hi", 64'(HI), 64'd0);
    check("rst/lo", 64'(LO), 64'd0);
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/done", 64'(done), 64'd0);
    check("rst/dz", 64'(divZero), 64'd0);
    reset = 1'b0;

    run_op(1, 0, 32'd7, -32'sd3, 0, 0, "mul7x-3");
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0, 0, "mulmin");
    run_op(0, 1, -32'sd7, 32'd2, 0, 0, "div-7/2");
    run_op(0, 1, 32'd5, 32'd0, 0, 0, "div0");
    run_op(1, 0, 32'd2, 32'd3, 0, 0, "mul2x3");
    run_op(1, 1, 32'd100, 32'd7, 5, 1, "both");
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "divovf");
    run_op(0, 1, 32'd9, -32'sd4, 0, 0, "div9/-4");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 1000))
                        : $urandom;
      if (rb == '0) rb = 32'd1;
      run_op(i[0] ? 1'b0 : 1'b1, i[0], ra, rb, 0, 0, "rnd");
    end

    // abort a divide with reset at edge N+10
    @(negedge clk);
    divOp = 1'b1;
    A     = 32'd1000;
    B     = 32'd3;
    @(negedge clk);
    divOp = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort/busy", 64'(busy), 64'd0);
    check("abort/done", 64'(done), 64'd0);
    check("abort/hi", 64'(HI), 64'd0);
    check("abort/lo", 64'(LO), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) ndone++;
      @(negedge clk);
    end
    check("abort/quiet", 64'(ndone), 64'd0);
    m_hi = '0;
    m_lo = '0;
    run_op(1, 0, -32'sd6, -32'sd7, 0, 0, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
